// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing a 2-read/1-write register file among several requesters.
// Optional RF_ARB_BYPASS_EN: forward same-cycle write data into read responses.
module rf_port_arbiter #(
  parameter int NUM_RD_REQ = 4,
  parameter int NUM_WR_REQ = 2,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD_REQ-1:0]        rd_req_valid,
  input  logic [NUM_RD_REQ*ADDR_W-1:0] rd_req_addr,
  output logic [NUM_RD_REQ-1:0]        rd_req_ready,
  output logic [NUM_RD_REQ-1:0]        rd_rsp_valid,
  output logic [NUM_RD_REQ*DATA_W-1:0] rd_rsp_data,
  input  logic [NUM_WR_REQ-1:0]        wr_req_valid,
  input  logic [NUM_WR_REQ*ADDR_W-1:0] wr_req_addr,
  input  logic [NUM_WR_REQ*DATA_W-1:0] wr_req_data,
  output logic [NUM_WR_REQ-1:0]        wr_req_ready,
  output logic [1:0]                   rf_read_en,
  output logic [ADDR_W-1:0]            rf_raddr_0,
  output logic [ADDR_W-1:0]            rf_raddr_1,
  output logic                         rf_write_en,
  output logic [ADDR_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  input  logic [DATA_W-1:0]            rf_rdata_0,
  input  logic [DATA_W-1:0]            rf_rdata_1
);

  localparam int RD_PW = $clog2(NUM_RD_REQ);
  localparam int WR_PW = (NUM_WR_REQ > 1) ? $clog2(NUM_WR_REQ) : 1;

  logic [RD_PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [WR_PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [NUM_RD_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_RD_REQ*DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic             g0_found, g1_found;
  logic [RD_PW-1:0] g0_idx, g1_idx, rd_cand;
  logic             w_found;
  logic [WR_PW-1:0] w_idx, wr_cand;
  logic [DATA_W-1:0] cap_data_0, cap_data_1;

  // Read scheduler: first two valid requesters from rd_ptr take ports 0 and 1.
  always_comb begin
    g0_found     = 1'b0;
    g1_found     = 1'b0;
    g0_idx       = '0;
    g1_idx       = '0;
    rd_cand      = '0;
    rd_req_ready = '0;
    rf_read_en   = 2'b00;
    rf_raddr_0   = '0;
    rf_raddr_1   = '0;
    rd_ptr_d     = rd_ptr_q;
    for (int k = 0; k < NUM_RD_REQ; k++) begin
      rd_cand = RD_PW'((int'(rd_ptr_q) + k) % NUM_RD_REQ);
      if (!reset && rd_req_valid[rd_cand]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = rd_cand;
        end else if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = rd_cand;
        end
      end
    end
    if (g0_found) begin
      rd_req_ready[g0_idx] = 1'b1;
      rf_read_en[0]        = 1'b1;
      rf_raddr_0           = rd_req_addr[int'(g0_idx)*ADDR_W +: ADDR_W];
      rd_ptr_d             = RD_PW'((int'(g0_idx) + 1) % NUM_RD_REQ);
    end
    if (g1_found) begin
      rd_req_ready[g1_idx] = 1'b1;
      rf_read_en[1]        = 1'b1;
      rf_raddr_1           = rd_req_addr[int'(g1_idx)*ADDR_W +: ADDR_W];
      rd_ptr_d             = RD_PW'((int'(g1_idx) + 1) % NUM_RD_REQ);
    end
  end

  always_comb begin
    w_found      = 1'b0;
    w_idx        = '0;
    wr_cand      = '0;
    wr_req_ready = '0;
    rf_write_en  = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    wr_ptr_d     = wr_ptr_q;
    for (int k = 0; k < NUM_WR_REQ; k++) begin
      wr_cand = WR_PW'((int'(wr_ptr_q) + k) % NUM_WR_REQ);
      if (!reset && !w_found && wr_req_valid[wr_cand]) begin
        w_found = 1'b1;
        w_idx   = wr_cand;
      end
    end
    if (w_found) begin
      wr_req_ready[w_idx] = 1'b1;
      rf_write_en         = 1'b1;
      rf_waddr            = wr_req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
      rf_wdata            = wr_req_data[int'(w_idx)*DATA_W +: DATA_W];
      wr_ptr_d            = WR_PW'((int'(w_idx) + 1) % NUM_WR_REQ);
    end
  end

`ifdef RF_ARB_BYPASS_EN
  assign cap_data_0 = (rf_write_en && (rf_raddr_0 == rf_waddr)) ? rf_wdata : rf_rdata_0;
  assign cap_data_1 = (rf_write_en && (rf_raddr_1 == rf_waddr)) ? rf_wdata : rf_rdata_1;
`else
  assign cap_data_0 = rf_rdata_0;
  assign cap_data_1 = rf_rdata_1;
`endif

  // Only granted slices are refreshed; the rest keep their last response.
  always_comb begin
    rsp_valid_d = rd_req_ready;
    rsp_data_d  = rsp_data_q;
    if (g0_found) rsp_data_d[int'(g0_idx)*DATA_W +: DATA_W] = cap_data_0;
    if (g1_found) rsp_data_d[int'(g1_idx)*DATA_W +: DATA_W] = cap_data_1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural register file behind it.
// Build with +define+RF_ARB_BYPASS_EN to check the forwarding variant.
module tb_rf_port_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   rd_req_valid;
  logic [19:0]  rd_req_addr;
  logic [3:0]   rd_req_ready;
  logic [3:0]   rd_rsp_valid;
  logic [127:0] rd_rsp_data;
  logic [1:0]   wr_req_valid;
  logic [9:0]   wr_req_addr;
  logic [63:0]  wr_req_data;
  logic [1:0]   wr_req_ready;
  logic [1:0]   rf_read_en;
  logic [4:0]   rf_raddr_0, rf_raddr_1, rf_waddr;
  logic         rf_write_en;
  logic [31:0]  rf_wdata, rf_rdata_0, rf_rdata_1;

  logic [4:0]   ra [4];
  logic [4:0]   wa [2];
  logic [31:0]  wd [2];
  logic [31:0]  rf_mem [32];
  logic         mem_init = 1'b0;

  int vectors = 0;
  int miscompares = 0;

`ifdef RF_ARB_BYPASS_EN
  localparam logic [31:0] RAW_EXP = 32'hA5A5_A5A5;
`else
  localparam logic [31:0] RAW_EXP = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  assign rd_req_addr = {ra[3], ra[2], ra[1], ra[0]};
  assign wr_req_addr = {wa[1], wa[0]};
  assign wr_req_data = {wd[1], wd[0]};
  assign rf_rdata_0  = rf_mem[rf_raddr_0];
  assign rf_rdata_1  = rf_mem[rf_raddr_1];

  // Register file model: preset contents C0DE_00nn except reg 7 = 0, writes commit at the edge.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 7) ? 32'h0 : (32'hC0DE_0000 | 32'(i));
      mem_init <= 1'b1;
    end else if (rf_write_en) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  rf_port_arbiter #(.NUM_RD_REQ(4), .NUM_WR_REQ(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_ready(wr_req_ready),
    .rf_read_en(rf_read_en), .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1)
  );

  function automatic logic [31:0] rsp(input int i);
    return rd_rsp_data[i*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    rd_req_valid = 4'b1111;
    wr_req_valid = 2'b11;
    ra[0] = 5'd10; ra[1] = 5'd11; ra[2] = 5'd12; ra[3] = 5'd13;
    wa[0] = 5'd1;  wa[1] = 5'd2;
    wd[0] = 32'h1111; wd[1] = 32'h2222;
    tick(); tick(); tick();
    chk("rst_rd_ready", 32'(rd_req_ready), 32'h0);
    chk("rst_wr_ready", 32'(wr_req_ready), 32'h0);
    chk("rst_read_en", 32'(rf_read_en), 32'h0);
    chk("rst_write_en", 32'(rf_write_en), 32'h0);
    chk("rst_rsp_valid", 32'(rd_rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(|rd_rsp_data), 32'h0);

    // All four readers continuously valid: pairs {0,1},{2,3},{0,1}
    reset = 1'b0; wr_req_valid = 2'b00;
    #1;
    chk("rr1_ready", 32'(rd_req_ready), 32'h3);
    chk("rr1_read_en", 32'(rf_read_en), 32'h3);
    chk("rr1_raddr0", 32'(rf_raddr_0), 32'd10);
    chk("rr1_raddr1", 32'(rf_raddr_1), 32'd11);
    tick();
    chk("rr1_rsp_valid", 32'(rd_rsp_valid), 32'h3);
    chk("rr1_rsp0", rsp(0), 32'hC0DE_000A);
    chk("rr1_rsp1", rsp(1), 32'hC0DE_000B);
    chk("rr2_ready", 32'(rd_req_ready), 32'hC);
    chk("rr2_raddr0", 32'(rf_raddr_0), 32'd12);
    chk("rr2_raddr1", 32'(rf_raddr_1), 32'd13);
    tick();
    chk("rr2_rsp_valid", 32'(rd_rsp_valid), 32'hC);
    chk("rr2_rsp2", rsp(2), 32'hC0DE_000C);
    chk("rr2_rsp3", rsp(3), 32'hC0DE_000D);
    chk("rr2_rsp0_hold", rsp(0), 32'hC0DE_000A);
    chk("rr3_ready", 32'(rd_req_ready), 32'h3);
    tick();
    chk("rr3_rsp_valid", 32'(rd_rsp_valid), 32'h3);

    // Write 5 = DEADBEEF, then reader 2 reads it back
    rd_req_valid = 4'b0000; wr_req_valid = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
    #1;
    chk("w5_wr_ready", 32'(wr_req_ready), 32'h1);
    chk("w5_write_en", 32'(rf_write_en), 32'h1);
    chk("w5_waddr", 32'(rf_waddr), 32'd5);
    chk("w5_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("w5_read_en", 32'(rf_read_en), 32'h0);
    tick();
    chk("w5_rsp_pulse_end", 32'(rd_rsp_valid), 32'h0);
    wr_req_valid = 2'b00; rd_req_valid = 4'b0100; ra[2] = 5'd5;
    #1;
    chk("r5_ready", 32'(rd_req_ready), 32'h4);
    chk("r5_read_en", 32'(rf_read_en), 32'h1);
    chk("r5_raddr0", 32'(rf_raddr_0), 32'd5);
    chk("r5_raddr1_idle", 32'(rf_raddr_1), 32'd0);
    tick();
    chk("r5_rsp_valid", 32'(rd_rsp_valid), 32'h4);
    chk("r5_rsp2", rsp(2), 32'hDEAD_BEEF);

    // Lone reader 3 at addr 31, then pointer wraps to 0
    rd_req_valid = 4'b1000; ra[3] = 5'd31;
    #1;
    chk("r31_ready", 32'(rd_req_ready), 32'h8);
    chk("r31_read_en", 32'(rf_read_en), 32'h1);
    chk("r31_raddr0", 32'(rf_raddr_0), 32'd31);
    tick();
    chk("r31_rsp3", rsp(3), 32'hC0DE_001F);
    rd_req_valid = 4'b1001; ra[0] = 5'd20;
    #1;
    chk("wrap_ready", 32'(rd_req_ready), 32'h9);
    chk("wrap_raddr0", 32'(rf_raddr_0), 32'd20);
    chk("wrap_raddr1", 32'(rf_raddr_1), 32'd31);
    tick();
    chk("wrap_rsp_valid", 32'(rd_rsp_valid), 32'h9);

    // Reset mid-operation drops the pending response
    reset = 1'b1; rd_req_valid = 4'b0001;
    #1;
    chk("mrst_ready", 32'(rd_req_ready), 32'h0);
    tick();
    chk("mrst_rsp_valid", 32'(rd_rsp_valid), 32'h0);
    chk("mrst_rsp_data", 32'(|rd_rsp_data), 32'h0);
    reset = 1'b0; rd_req_valid = 4'b0000;

    // Two writers continuously valid: grants 0,1,0
    wr_req_valid = 2'b11; wa[0] = 5'd1; wd[0] = 32'h1111; wa[1] = 5'd2; wd[1] = 32'h2222;
    #1;
    chk("ww1_ready", 32'(wr_req_ready), 32'h1);
    chk("ww1_waddr", 32'(rf_waddr), 32'd1);
    tick();
    chk("ww2_ready", 32'(wr_req_ready), 32'h2);
    chk("ww2_waddr", 32'(rf_waddr), 32'd2);
    chk("ww2_wdata", rf_wdata, 32'h2222);
    tick();
    chk("ww3_ready", 32'(wr_req_ready), 32'h1);
    tick();
    wr_req_valid = 2'b00; rd_req_valid = 4'b0011; ra[0] = 5'd1; ra[1] = 5'd2;
    tick();
    chk("reg1", rsp(0), 32'h0000_1111);
    chk("reg2", rsp(1), 32'h0000_2222);

    // Same-cycle write 7 and two readers of 7
    wr_req_valid = 2'b10; wa[1] = 5'd7; wd[1] = 32'hA5A5_A5A5;
    rd_req_valid = 4'b1100; ra[2] = 5'd7; ra[3] = 5'd7;
    #1;
    chk("raw_wr_ready", 32'(wr_req_ready), 32'h2);
    chk("raw_rd_ready", 32'(rd_req_ready), 32'hC);
    chk("raw_read_en", 32'(rf_read_en), 32'h3);
    tick();
    chk("raw_rsp2", rsp(2), RAW_EXP);
    chk("raw_rsp3", rsp(3), RAW_EXP);
    wr_req_valid = 2'b00; rd_req_valid = 4'b0001; ra[0] = 5'd7;
    tick();
    chk("post_raw_rsp0", rsp(0), 32'hA5A5_A5A5);

    // Register 0 is writable
    rd_req_valid = 4'b0000; wr_req_valid = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1234_5678;
    tick();
    wr_req_valid = 2'b00; rd_req_valid = 4'b0010; ra[1] = 5'd0;
    #1;
    chk("r0_ready", 32'(rd_req_ready), 32'h2);
    tick();
    chk("r0_rsp1", rsp(1), 32'h1234_5678);
    rd_req_valid = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the 2-read/1-write 32x32 register_file among NUM_RD_REQ read requesters and NUM_WR_REQ write requesters.
- Grants use independent round-robin schedulers.
- Drives the RF enables, addresses and write data, and returns registered read data to each requester one cycle after its grant.
- Sits between the issue/operand-fetch logic and register_file.

Parameters:
NUM_RD_REQ, 4, number of read requesters (2..8)
NUM_WR_REQ, 2, number of write requesters (1..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
rd_req_valid  in  NUM_RD_REQ  per-requester read request
rd_req_addr  in  NUM_RD_REQ*ADDR_W  packed read addresses; requester i uses slice i
rd_req_ready  out  NUM_RD_REQ  grant (combinational); the transfer completes when valid&&ready
rd_rsp_valid  out  NUM_RD_REQ  one-cycle pulse; response data valid
rd_rsp_data  out  NUM_RD_REQ*DATA_W  packed registered read data
wr_req_valid  in  NUM_WR_REQ  per-requester write request
wr_req_addr  in  NUM_WR_REQ*ADDR_W  packed write addresses
wr_req_data  in  NUM_WR_REQ*DATA_W  packed write data
wr_req_ready  out  NUM_WR_REQ  write grant (combinational)
rf_read_en  out  2  to register_file read_en; bit0 = port 0, bit1 = port 1
rf_raddr_0  out  ADDR_W  to register_file raddr_0
rf_raddr_1  out  ADDR_W  to register_file raddr_1
rf_write_en  out  1  to register_file write_en
rf_waddr  out  ADDR_W  to register_file waddr
rf_wdata  out  DATA_W  to register_file wdata
rf_rdata_0  in  DATA_W  from register_file; combinational read data, port 0
rf_rdata_1  in  DATA_W  from register_file; combinational read data, port 1

Behaviour:
- Single clock domain, clk. reset is synchronous, active-high.
- While reset=1:
  - all ready outputs, rf_read_en and rf_write_en are 0;
  - rd_rsp_valid is 0 and rd_rsp_data is 0;
  - rd_ptr and wr_ptr are 0.
- Reset asserted mid-operation discards in-flight responses: no rd_rsp_valid appears in the cycle after reset.

Read arbitration (combinational, each cycle):
- Scan requesters from index rd_ptr upward, modulo NUM_RD_REQ.
- The first valid requester gets port 0: rf_read_en[0]=1, rf_raddr_0 = its address.
- The second valid requester gets port 1: rf_read_en[1]=1, rf_raddr_1 = its address.
- Granted requesters see rd_req_ready=1. At most 2 grants per cycle.
- Unused port: its enable bit is 0 and its address is 0.

Read pointer update:
- At the clock edge, rd_ptr moves to (index of last granted + 1) mod NUM_RD_REQ.
- rd_ptr is unchanged when there are no grants.

Read response:
- At the grant edge, rf_rdata_0/1 is captured into the granted requester's rd_rsp_data slice.
- rd_rsp_valid for that requester is high for exactly the next cycle. Read latency = 1 cycle.
- Non-granted slices hold their previous data.

Write arbitration:
- Same round-robin scheme with wr_ptr; at most one grant per cycle.
- The grant drives rf_write_en=1 plus rf_waddr and rf_wdata from the winner.
- The RF commits the write at that edge. wr_ptr = winner+1 mod NUM_WR_REQ.

Rules that hold at all times:
- Read and write arbitration are independent; a read and a write may both be granted in the same cycle.
- Same-cycle read and write to the same address: the read returns the pre-write value (RF is read-before-write). This holds unless the optional feature below is compiled in.
- Two read requesters with the same address in one cycle are both granted, on separate ports, and both receive identical data.
- Register 0 is an ordinary writable register; there is no hardwired zero.
- Requesters hold valid and address stable until ready. The arbiter never deasserts a ready within a cycle.
- Fairness: a continuously valid read requester is granted within ceil(NUM_RD_REQ/2) cycles. A continuously valid write requester is granted within NUM_WR_REQ cycles.

Optional Feature:
RF_ARB_BYPASS_EN:
- Defined: when a granted read address equals rf_waddr with rf_write_en=1 in the same cycle, the captured response is rf_wdata instead of rf_rdata_x. This applies independently per port.
- Undefined: no forwarding. Same-cycle read-after-write returns the old value.

Test Plan:
- Reset held 3 cycles with all valids=1 -> all readies, rf_read_en, rf_write_en and rd_rsp_valid are 0. The first grant after release goes to rd requester 0 (port 0) and rd requester 1 (port 1).
- Write requester 0 writes addr 5 = 0xDEADBEEF; next cycle rd requester 2 reads addr 5 -> rd_rsp_valid[2]=1 one cycle after the grant, with rd_rsp_data slice 2 = 0xDEADBEEF.
- All 4 rd requesters valid continuously -> grant pairs per cycle are {0,1}, {2,3}, {0,1}. Each requester gets one response every 2 cycles.
- Only rd requester 3 valid, addr 31 -> port 0 granted, rf_read_en=2'b01, rf_raddr_0=31; rd_ptr then wraps to 0.
- Both write requesters valid continuously (addr 1 = 0x1111, addr 2 = 0x2222) -> alternating grants 0, 1, 0. Final RF contents are reg1=0x1111 and reg2=0x2222.
- Same cycle: write addr 7 = 0xA5A5A5A5 (old value 0x0) and read addr 7 -> response 0x0 without RF_ARB_BYPASS_EN, 0xA5A5A5A5 with it.
